id_ex_stage: RTL and testbench

- ID/EX pipeline register and EX operand selector of the 5-stage MIPS core.
- Captures decoded operands and controls from ID, then resolves EX/MEM and MEM/WB forwarding.
- Drives the ALU's A, B, ALUFun and Sign inputs, and carries store data and destination downstream.
- Raises the load-use hazard flag consumed by the hazard unit.

---
 rtl/mips_pkg.sv | 36 +++
 rtl/fwd_mux.sv | 37 +++
 rtl/id_ex_stage.sv | 170 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared ALU function codes and writeback-select encodings.
// Revision    : 1.0
// ============================================================================
package mips_pkg;

    localparam int XLEN  = 32;
    localparam int RADDR = 5;

    localparam logic [5:0] ALU_ADD   = 6'b000000;
    localparam logic [5:0] ALU_SUB   = 6'b000001;
    localparam logic [5:0] ALU_AND   = 6'b011000;
    localparam logic [5:0] ALU_OR    = 6'b011110;
    localparam logic [5:0] ALU_XOR   = 6'b010110;
    localparam logic [5:0] ALU_NOR   = 6'b010001;
    localparam logic [5:0] ALU_PASSA = 6'b011010;
    localparam logic [5:0] ALU_SLL   = 6'b100000;
    localparam logic [5:0] ALU_SRL   = 6'b100001;
    localparam logic [5:0] ALU_SRA   = 6'b100011;
    localparam logic [5:0] ALU_EQ    = 6'b110011;
    localparam logic [5:0] ALU_NEQ   = 6'b110001;
    localparam logic [5:0] ALU_LT    = 6'b110101;
    localparam logic [5:0] ALU_LEZ   = 6'b111101;
    localparam logic [5:0] ALU_LTZ   = 6'b111011;
    localparam logic [5:0] ALU_GTZ   = 6'b111111;

    typedef enum logic [1:0] {
        MTR_ALU = 2'b00,
        MTR_MEM = 2'b01,
        MTR_PC  = 2'b10
    } memtoreg_e;

endpackage
`default_nettype wire

// File: rtl/fwd_mux.sv
`default_nettype none
// ============================================================================
// Module      : fwd_mux
// Description : Operand bypass select; EX/MEM beats MEM/WB, r0 never bypasses.
// Revision    : 1.0
// ============================================================================
module fwd_mux #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
) (
    input  logic [RADDR-1:0] i_idx,
    input  logic [XLEN-1:0]  i_data,
    input  logic             i_exmem_regwrite,
    input  logic [RADDR-1:0] i_exmem_rd,
    input  logic [XLEN-1:0]  i_exmem_result,
    input  logic             i_memwb_regwrite,
    input  logic [RADDR-1:0] i_memwb_rd,
    input  logic [XLEN-1:0]  i_memwb_result,
    output logic [XLEN-1:0]  o_fwd
);

    logic w_hit_exmem;
    logic w_hit_memwb;

    assign w_hit_exmem = i_exmem_regwrite && (i_exmem_rd != '0) && (i_exmem_rd == i_idx);
    assign w_hit_memwb = i_memwb_regwrite && (i_memwb_rd != '0) && (i_memwb_rd == i_idx);

    always_comb begin
        o_fwd = i_data;
        if (w_hit_exmem)
            o_fwd = i_exmem_result;
        else if (w_hit_memwb)
            o_fwd = i_memwb_result;
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with EX operand forwarding and
//               load-use hazard detection.
// Revision    : 1.0
// ============================================================================
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs_data,
    input  logic [XLEN-1:0]  id_rt_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_shamt,
    input  logic [RADDR-1:0] id_rs,
    input  logic [RADDR-1:0] id_rt,
    input  logic [RADDR-1:0] id_dst,
    input  logic [5:0]       id_alufun,
    input  logic             id_sign,
    input  logic             id_alusrc1,
    input  logic             id_alusrc2,
    input  logic             id_uses_rt,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_memwrite,
    input  logic [1:0]       id_memtoreg,
    input  logic             exmem_regwrite,
    input  logic [RADDR-1:0] exmem_rd,
    input  logic [XLEN-1:0]  exmem_result,
    input  logic             memwb_regwrite,
    input  logic [RADDR-1:0] memwb_rd,
    input  logic [XLEN-1:0]  memwb_result,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    output logic [5:0]       alu_fun,
    output logic             alu_sign,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_store_data,
    output logic [RADDR-1:0] ex_dst,
    output logic             ex_regwrite,
    output logic             ex_memread,
    output logic             ex_memwrite,
    output logic [1:0]       ex_memtoreg,
    output logic             load_use_hazard
);

    logic             r_valid;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_rs_data;
    logic [XLEN-1:0]  r_rt_data;
    logic [XLEN-1:0]  r_imm;
    logic [4:0]       r_shamt;
    logic [RADDR-1:0] r_rs;
    logic [RADDR-1:0] r_rt;
    logic [RADDR-1:0] r_dst;
    logic [5:0]       r_alufun;
    logic             r_sign;
    logic             r_alusrc1;
    logic             r_alusrc2;
    logic             r_regwrite;
    logic             r_memread;
    logic             r_memwrite;
    logic [1:0]       r_memtoreg;

    logic [XLEN-1:0]  w_rs_fwd;
    logic [XLEN-1:0]  w_rt_fwd;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs_data  <= '0;
            r_rt_data  <= '0;
            r_imm      <= '0;
            r_shamt    <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_dst      <= '0;
            r_alufun   <= ALU_ADD;
            r_sign     <= 1'b0;
            r_alusrc1  <= 1'b0;
            r_alusrc2  <= 1'b0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_memtoreg <= '0;
        end else if (flush) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_memtoreg <= '0;
            r_alufun   <= ALU_ADD;
        end else if (stall) begin
            // Latch bypassed values so they survive their producer retiring.
            r_rs_data  <= w_rs_fwd;
            r_rt_data  <= w_rt_fwd;
        end else begin
            r_valid    <= id_valid;
            r_pc       <= id_pc;
            r_rs_data  <= id_rs_data;
            r_rt_data  <= id_rt_data;
            r_imm      <= id_imm;
            r_shamt    <= id_shamt;
            r_rs       <= id_rs;
            r_rt       <= id_rt;
            r_dst      <= id_dst;
            r_alufun   <= id_alufun;
            r_sign     <= id_sign;
            r_alusrc1  <= id_alusrc1;
            r_alusrc2  <= id_alusrc2;
            r_regwrite <= id_regwrite;
            r_memread  <= id_memread;
            r_memwrite <= id_memwrite;
            r_memtoreg <= id_memtoreg;
        end
    end

    fwd_mux #(.XLEN(XLEN), .RADDR(RADDR)) u_fwd_rs (
        .i_idx            (r_rs),
        .i_data           (r_rs_data),
        .i_exmem_regwrite (exmem_regwrite),
        .i_exmem_rd       (exmem_rd),
        .i_exmem_result   (exmem_result),
        .i_memwb_regwrite (memwb_regwrite),
        .i_memwb_rd       (memwb_rd),
        .i_memwb_result   (memwb_result),
        .o_fwd            (w_rs_fwd)
    );

    fwd_mux #(.XLEN(XLEN), .RADDR(RADDR)) u_fwd_rt (
        .i_idx            (r_rt),
        .i_data           (r_rt_data),
        .i_exmem_regwrite (exmem_regwrite),
        .i_exmem_rd       (exmem_rd),
        .i_exmem_result   (exmem_result),
        .i_memwb_regwrite (memwb_regwrite),
        .i_memwb_rd       (memwb_rd),
        .i_memwb_result   (memwb_result),
        .o_fwd            (w_rt_fwd)
    );

    assign alu_a         = r_alusrc1 ? {{(XLEN-5){1'b0}}, r_shamt} : w_rs_fwd;
    assign alu_b         = r_alusrc2 ? r_imm : w_rt_fwd;
    assign alu_fun       = r_alufun;
    assign alu_sign      = r_sign;
    assign ex_valid      = r_valid;
    assign ex_pc         = r_pc;
    assign ex_store_data = w_rt_fwd;
    assign ex_dst        = r_dst;
    assign ex_regwrite   = r_regwrite;
    assign ex_memread    = r_memread;
    assign ex_memwrite   = r_memwrite;
    assign ex_memtoreg   = r_memtoreg;

    assign load_use_hazard = id_valid && r_valid && r_memread && (r_dst != '0) &&
                             ((r_dst == id_rs) || (id_uses_rt && (r_dst == id_rt)));

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Self-checking bench for id_ex_stage with a behavioural model.
// Revision    : 1.0
// ============================================================================
module tb_id_ex_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset, stall, flush, id_valid;
    logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_shamt, id_rs, id_rt, id_dst;
    logic [5:0]  id_alufun;
    logic        id_sign, id_alusrc1, id_alusrc2, id_uses_rt;
    logic        id_regwrite, id_memread, id_memwrite;
    logic [1:0]  id_memtoreg;
    logic        exmem_regwrite, memwb_regwrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] alu_a, alu_b, ex_pc, ex_store_data;
    logic [5:0]  alu_fun;
    logic        alu_sign, ex_valid, ex_regwrite, ex_memread, ex_memwrite, load_use_hazard;
    logic [4:0]  ex_dst;
    logic [1:0]  ex_memtoreg;

    int n_checks = 0;
    int n_fail   = 0;

    // Architectural view of what the EX stage currently holds
    logic        m_valid, m_sign, m_src1, m_src2, m_rw, m_mr, m_mw;
    logic [31:0] m_pc, m_rs_data, m_rt_data, m_imm;
    logic [4:0]  m_shamt, m_rs, m_rt, m_dst;
    logic [5:0]  m_fun;
    logic [1:0]  m_mtr;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
        .id_alufun(id_alufun), .id_sign(id_sign), .id_alusrc1(id_alusrc1), .id_alusrc2(id_alusrc2),
        .id_uses_rt(id_uses_rt), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_sign(alu_sign),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_store_data(ex_store_data), .ex_dst(ex_dst),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_memtoreg(ex_memtoreg), .load_use_hazard(load_use_hazard)
    );

    // Value a register read of architectural reg idx sees, given older copy d
    function automatic logic [31:0] latest(input logic [4:0] idx, input logic [31:0] d);
        if (idx == 5'd0)                                 return d;
        if (exmem_regwrite && exmem_rd == idx)           return exmem_result;
        if (memwb_regwrite && memwb_rd == idx)           return memwb_result;
        return d;
    endfunction

    task automatic model_update();
        logic [31:0] rs_now, rt_now;
        rs_now = latest(m_rs, m_rs_data);
        rt_now = latest(m_rt, m_rt_data);
        if (reset) begin
            {m_valid, m_sign, m_src1, m_src2, m_rw, m_mr, m_mw} = '0;
            {m_pc, m_rs_data, m_rt_data, m_imm} = '0;
            {m_shamt, m_rs, m_rt, m_dst} = '0;
            m_fun = ALU_ADD;
            m_mtr = '0;
        end else if (flush) begin
            {m_valid, m_rw, m_mr, m_mw} = '0;
            m_mtr = '0;
            m_fun = ALU_ADD;
        end else if (stall) begin
            m_rs_data = rs_now;
            m_rt_data = rt_now;
        end else begin
            m_valid = id_valid;  m_pc = id_pc;  m_rs_data = id_rs_data;  m_rt_data = id_rt_data;
            m_imm = id_imm;  m_shamt = id_shamt;  m_rs = id_rs;  m_rt = id_rt;  m_dst = id_dst;
            m_fun = id_alufun;  m_sign = id_sign;  m_src1 = id_alusrc1;  m_src2 = id_alusrc2;
            m_rw = id_regwrite;  m_mr = id_memread;  m_mw = id_memwrite;  m_mtr = id_memtoreg;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        {reset, stall, flush, id_valid} = '0;
        {id_pc, id_rs_data, id_rt_data, id_imm} = '0;
        {id_shamt, id_rs, id_rt, id_dst} = '0;
        id_alufun = ALU_ADD;
        {id_sign, id_alusrc1, id_alusrc2, id_uses_rt, id_regwrite, id_memread, id_memwrite} = '0;
        id_memtoreg = '0;
        {exmem_regwrite, memwb_regwrite} = '0;
        {exmem_rd, memwb_rd} = '0;
        {exmem_result, memwb_result} = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        id_valid = 1; id_pc = 32'h400; id_rs_data = 32'h1; id_rt_data = 32'h2; id_imm = 32'h3;
        id_rs = 5'd1; id_rt = 5'd2; id_dst = 5'd3; id_alufun = ALU_SUB; id_sign = 1;
        id_regwrite = 1; id_memread = 1; id_memwrite = 1; id_memtoreg = 2'd1;
        step();
        reset = 1;
        step();
        reset = 0;
        id_valid = 1; id_rs = 5'd0; id_rt = 5'd0;
        #1;
        n_checks++;
        if ({alu_a, alu_b, ex_pc, ex_store_data} !== 128'd0) begin
            n_fail++;
            $display("FAIL reset_data: a=%h b=%h pc=%h sd=%h, want all 0", alu_a, alu_b, ex_pc, ex_store_data);
        end
        n_checks++;
        if ({alu_fun, alu_sign, ex_valid, ex_dst, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: fun=%b sign=%b v=%b dst=%0d rw=%b mr=%b mw=%b mtr=%0d, want 0",
                     alu_fun, alu_sign, ex_valid, ex_dst, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg);
        end
        n_checks++;
        if (load_use_hazard !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hazard: got %b want 0", load_use_hazard);
        end
    endtask

    task automatic test_fwd_priority();
        clear_inputs();
        id_valid = 1; id_rs = 5'd5; id_rs_data = 32'h99;
        step();
        exmem_regwrite = 1; exmem_rd = 5'd5; exmem_result = 32'h11;
        memwb_regwrite = 1; memwb_rd = 5'd5; memwb_result = 32'h22;
        #1;
        n_checks++;
        if (alu_a !== 32'h11) begin n_fail++; $display("FAIL fwd_exmem: got %h want 00000011", alu_a); end
        exmem_regwrite = 0;
        #1;
        n_checks++;
        if (alu_a !== 32'h22) begin n_fail++; $display("FAIL fwd_memwb: got %h want 00000022", alu_a); end
        exmem_regwrite = 1; exmem_rd = 5'd0; memwb_rd = 5'd0;
        #1;
        n_checks++;
        if (alu_a !== 32'h99) begin n_fail++; $display("FAIL fwd_r0: got %h want 00000099", alu_a); end
    endtask

    task automatic test_stall_refresh();
        clear_inputs();
        id_valid = 1; id_rs = 5'd3; id_rs_data = 32'hAAAA;
        step();
        stall = 1; id_rs_data = 32'hDEAD; id_rs = 5'd7;
        memwb_regwrite = 1; memwb_rd = 5'd3; memwb_result = 32'h1234;
        step();
        memwb_regwrite = 0; memwb_result = 32'h0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (alu_a !== 32'h1234) begin
                n_fail++;
                $display("FAIL stall_refresh[%0d]: got %h want 00001234", i, alu_a);
            end
            step();
        end
        stall = 0;
    endtask

    task automatic test_flush();
        clear_inputs();
        id_valid = 1; id_pc = 32'h1000; id_alufun = ALU_OR; id_regwrite = 1;
        id_memread = 1; id_memwrite = 1; id_memtoreg = 2'd2;
        step();
        flush = 1; stall = 1; id_pc = 32'h2000;
        step();
        flush = 0; stall = 0;
        #1;
        n_checks++;
        if ({ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, alu_fun} !== 12'd0) begin
            n_fail++;
            $display("FAIL flush_ctrl: v=%b rw=%b mr=%b mw=%b mtr=%0d fun=%b, want 0",
                     ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, alu_fun);
        end
        n_checks++;
        if (ex_pc !== 32'h1000) begin n_fail++; $display("FAIL flush_hold_pc: got %h want 00001000", ex_pc); end
    endtask

    task automatic test_load_use();
        clear_inputs();
        id_valid = 1; id_memread = 1; id_regwrite = 1; id_dst = 5'd8;
        step();
        id_memread = 0; id_rs = 5'd8; #1;
        n_checks++;
        if (load_use_hazard !== 1'b1) begin n_fail++; $display("FAIL lu_rs: got %b want 1", load_use_hazard); end
        id_rs = 5'd0; id_rt = 5'd8; id_uses_rt = 0; #1;
        n_checks++;
        if (load_use_hazard !== 1'b0) begin n_fail++; $display("FAIL lu_rt_unused: got %b want 0", load_use_hazard); end
        id_uses_rt = 1; #1;
        n_checks++;
        if (load_use_hazard !== 1'b1) begin n_fail++; $display("FAIL lu_rt_used: got %b want 1", load_use_hazard); end
        id_valid = 0; #1;
        n_checks++;
        if (load_use_hazard !== 1'b0) begin n_fail++; $display("FAIL lu_id_invalid: got %b want 0", load_use_hazard); end
        id_valid = 1; id_memread = 1; id_dst = 5'd0; id_rs = 5'd8;
        step();
        id_memread = 0; id_rs = 5'd0; id_rt = 5'd0; #1;
        n_checks++;
        if (load_use_hazard !== 1'b0) begin n_fail++; $display("FAIL lu_dst0: got %b want 0", load_use_hazard); end
    endtask

    task automatic test_operand_select();
        clear_inputs();
        id_valid = 1; id_alufun = ALU_SRA; id_alusrc1 = 1; id_shamt = 5'd4;
        id_rs = 5'd2; id_rs_data = 32'hFFFF; id_rt = 5'd9; id_rt_data = 32'h80000000;
        step();
        n_checks++;
        if (alu_a !== 32'd4 || alu_b !== 32'h80000000 || alu_fun !== ALU_SRA) begin
            n_fail++;
            $display("FAIL sra_sel: a=%h b=%h fun=%b want 00000004 80000000 %b", alu_a, alu_b, alu_fun, ALU_SRA);
        end
        clear_inputs();
        id_valid = 1; id_alusrc2 = 1; id_imm = 32'hFFFFFFFC; id_rt = 5'd6; id_rt_data = 32'h0; id_memwrite = 1;
        step();
        exmem_regwrite = 1; exmem_rd = 5'd6; exmem_result = 32'h55;
        #1;
        n_checks++;
        if (alu_b !== 32'hFFFFFFFC || ex_store_data !== 32'h55) begin
            n_fail++;
            $display("FAIL sw_sel: b=%h sd=%h want fffffffc 00000055", alu_b, ex_store_data);
        end
    endtask

    task automatic test_random();
        logic [31:0] e_a, e_b, e_sd;
        logic        e_hz;
        clear_inputs();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 3) == 0);
            id_valid = $urandom; id_pc = $urandom; id_rs_data = $urandom; id_rt_data = $urandom;
            id_imm = $urandom; id_shamt = $urandom; id_rs = $urandom_range(0, 7);
            id_rt = $urandom_range(0, 7); id_dst = $urandom_range(0, 7); id_alufun = $urandom;
            {id_sign, id_alusrc1, id_alusrc2, id_uses_rt} = $urandom;
            {id_regwrite, id_memread, id_memwrite} = $urandom; id_memtoreg = $urandom;
            exmem_regwrite = $urandom; exmem_rd = $urandom_range(0, 7); exmem_result = $urandom;
            memwb_regwrite = $urandom; memwb_rd = $urandom_range(0, 7); memwb_result = $urandom;
            step();
            exmem_regwrite = $urandom; exmem_rd = $urandom_range(0, 7); exmem_result = $urandom;
            memwb_regwrite = $urandom; memwb_rd = $urandom_range(0, 7); memwb_result = $urandom;
            #1;
            e_a  = m_src1 ? {27'd0, m_shamt} : latest(m_rs, m_rs_data);
            e_b  = m_src2 ? m_imm : latest(m_rt, m_rt_data);
            e_sd = latest(m_rt, m_rt_data);
            e_hz = id_valid && m_valid && m_mr && m_dst != 0 &&
                   (m_dst == id_rs || (id_uses_rt && m_dst == id_rt));
            n_checks++;
            if (alu_a !== e_a || alu_b !== e_b) begin
                n_fail++;
                $display("FAIL rnd_alu_ops[%0d]: a=%h b=%h want %h %h", i, alu_a, alu_b, e_a, e_b);
            end
            n_checks++;
            if (ex_store_data !== e_sd) begin
                n_fail++;
                $display("FAIL rnd_store[%0d]: got %h want %h", i, ex_store_data, e_sd);
            end
            n_checks++;
            if ({alu_fun, alu_sign, ex_valid, ex_pc, ex_dst} !== {m_fun, m_sign, m_valid, m_pc, m_dst}) begin
                n_fail++;
                $display("FAIL rnd_state[%0d]: fun=%b s=%b v=%b pc=%h dst=%0d want %b %b %b %h %0d", i,
                         alu_fun, alu_sign, ex_valid, ex_pc, ex_dst, m_fun, m_sign, m_valid, m_pc, m_dst);
            end
            n_checks++;
            if ({ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg} !== {m_rw, m_mr, m_mw, m_mtr}) begin
                n_fail++;
                $display("FAIL rnd_ctrl[%0d]: got %b%b%b %0d want %b%b%b %0d", i,
                         ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, m_rw, m_mr, m_mw, m_mtr);
            end
            n_checks++;
            if (load_use_hazard !== e_hz) begin
                n_fail++;
                $display("FAIL rnd_hazard[%0d]: got %b want %b", i, load_use_hazard, e_hz);
            end
        end
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        @(negedge clk);
        step();
        test_reset();
        test_fwd_priority();
        test_stall_refresh();
        test_flush();
        test_load_use();
        test_operand_select();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
